// File: rtl/rob_commit.sv
// Reorder buffer: tags dispatched instructions, captures CDB results, retires in program order.
// Latency: alloc tag combinational; CDB-to-commit one cycle; one commit per cycle. Optional ROB_CDB_BYPASS_EN.
// Backpressure: alloc_gnt drops while full, during flush or while in reset; commit never stalls.
module rob_commit #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 32,
    localparam int TW    = $clog2(DEPTH),
    localparam int CW    = TW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             alloc_req,
    input  logic [4:0]       alloc_rd,
    output logic             alloc_gnt,
    output logic [TW-1:0]    alloc_tag,
    output logic             rf_ld_instr,
    input  logic             cdb_valid,
    input  logic [TW-1:0]    cdb_tag,
    input  logic [WIDTH-1:0] cdb_data,
    output logic             commit_rdy,
    output logic [TW-1:0]    commit_tag,
    output logic [WIDTH-1:0] commit_data,
    output logic [4:0]       commit_rd,
    input  logic             flush,
    input  logic [TW-1:0]    q1_tag,
    input  logic [TW-1:0]    q2_tag,
    output logic             q1_rdy,
    output logic             q2_rdy,
    output logic [WIDTH-1:0] q1_data,
    output logic [WIDTH-1:0] q2_data,
    output logic             full,
    output logic             empty
);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q,  done_d;
    logic [4:0]       rd_q   [DEPTH];
    logic [4:0]       rd_d   [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [TW-1:0]    head_q, head_d;
    logic [TW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    assign full        = (count_q == CW'(DEPTH));
    assign empty       = (count_q == '0);
    // Reset is folded in so a request held through reset is never reported as granted.
    assign alloc_gnt   = alloc_req & ~full & ~flush & rst;
    assign alloc_tag   = tail_q;
    assign rf_ld_instr = alloc_gnt & (alloc_rd != 5'd0);

    assign commit_rdy  = valid_q[head_q] & done_q[head_q] & ~flush;
    assign commit_tag  = head_q;
    assign commit_data = data_q[head_q];
    assign commit_rd   = rd_q[head_q];

    always_comb begin
        valid_d = valid_q;
        done_d  = done_q;
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            valid_d = '0;
            done_d  = '0;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (cdb_valid && valid_q[cdb_tag]) begin
                done_d[cdb_tag] = 1'b1;
                data_d[cdb_tag] = cdb_data;
            end
            if (commit_rdy) begin
                valid_d[head_q] = 1'b0;
                done_d[head_q]  = 1'b0;
                head_d          = head_q + 1'b1;
            end
            // Tail only collides with head when full, and full blocks allocation.
            if (alloc_gnt) begin
                valid_d[tail_q] = 1'b1;
                done_d[tail_q]  = 1'b0;
                rd_d[tail_q]    = alloc_rd;
                data_d[tail_q]  = '0;
                tail_d          = tail_q + 1'b1;
            end
            count_d = count_q + CW'(alloc_gnt) - CW'(commit_rdy);
        end
    end

    always_comb begin
        q1_rdy  = valid_q[q1_tag] & done_q[q1_tag];
        q2_rdy  = valid_q[q2_tag] & done_q[q2_tag];
        q1_data = q1_rdy ? data_q[q1_tag] : '0;
        q2_data = q2_rdy ? data_q[q2_tag] : '0;
`ifdef ROB_CDB_BYPASS_EN
        if (cdb_valid && (cdb_tag == q1_tag) && valid_q[q1_tag]) begin
            q1_rdy  = 1'b1;
            q1_data = cdb_data;
        end
        if (cdb_valid && (cdb_tag == q2_tag) && valid_q[q2_tag]) begin
            q2_rdy  = 1'b1;
            q2_data = cdb_data;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q <= '0;
            done_q  <= '0;
            rd_q    <= '{default: '0};
            data_q  <= '{default: '0};
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

endmodule
